// File: rtl/stream_pkg.sv
// Shared definitions for the 4-bit master-flag / 2-bit slave-flag stream protocol.
package stream_pkg;

    localparam int unsigned MF_W = 4;
    localparam int unsigned SF_W = 2;

    localparam int unsigned MF_VLD   = 0;
    localparam int unsigned MF_LAST  = 1;
    localparam int unsigned MF_FIRST = 2;
    localparam int unsigned MF_AGAIN = 3;

    localparam int unsigned SF_BSY = 0;
    localparam int unsigned SF_ABT = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PKT  = 2'd1,
        DROP = 2'd2
    } sink_state_e;

    // Saturating 16-bit increment for event counters.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : 16'(v + 16'd1);
    endfunction

endpackage

// File: rtl/sink_mem.sv
// Packet FIFO storage: DEPTH x WIDTH registers, synchronous write, asynchronous read.
module sink_mem #(
    parameter int unsigned WIDTH = 34,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // No reset: readers qualify the output with the committed-data valid.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stream_pkt_sink.sv
// Terminal stream receiver with packet FIFO, commit/rewind and busy/abort flag generation.
// Optional STREAM_SINK_STATS_EN adds saturating pkt_cnt / abt_cnt outputs.
module stream_pkt_sink
    import stream_pkg::*;
#(
    parameter int unsigned W      = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned MAXLEN = 256
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [W-1:0]    uc_d0,
    input  logic [MF_W-1:0] uc_mflags,
    output logic [SF_W-1:0] cu_sflags,
    output logic [W-1:0]    rd_data,
    output logic            rd_first,
    output logic            rd_last,
    output logic            rd_vld,
    input  logic            rd_rdy
`ifdef STREAM_SINK_STATS_EN
    ,
    output logic [15:0]     pkt_cnt,
    output logic [15:0]     abt_cnt
`endif
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = AW + 1;
    localparam int unsigned LW = $clog2(MAXLEN + 1);
    localparam int unsigned MW = W + 2;

    sink_state_e   state_q, state_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] cm_q, cm_d;
    logic [PW-1:0] rd_q;
    logic [LW-1:0] len_q, len_d;
    logic          abt_q, abt_d;
    logic          commit_ev;

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [MW-1:0] mem_wdata;
    logic [MW-1:0] mem_rdata;

    logic uc_vld, uc_last, uc_first, uc_again;
    logic full, bsy, offered, acc, pop, deadlock;
    logic [PW-1:0] wr_inc, cm_inc;

    assign uc_vld   = uc_mflags[MF_VLD];
    assign uc_last  = uc_mflags[MF_LAST];
    assign uc_first = uc_mflags[MF_FIRST];
    assign uc_again = uc_mflags[MF_AGAIN];

    // Flow control is decoded from registered state only.
    assign full     = (PW'(wr_q - rd_q) == PW'(DEPTH));
    assign bsy      = full & (state_q != DROP);
    assign offered  = uc_vld & ~uc_again;
    assign acc      = offered & ~bsy;
    assign deadlock = (state_q == PKT) & full & (cm_q == rd_q);

    assign rd_vld   = (cm_q != rd_q);
    assign pop      = rd_vld & rd_rdy;

    assign wr_inc   = PW'(wr_q + PW'(1));
    assign cm_inc   = PW'(cm_q + PW'(1));

    assign mem_wdata = {uc_first, uc_last, uc_d0};

    always_comb begin
        cu_sflags         = '0;
        cu_sflags[SF_BSY] = bsy;
        cu_sflags[SF_ABT] = abt_q;
    end

    // Next-state, pointer and write-port control.
    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        cm_d      = cm_q;
        len_d     = len_q;
        abt_d     = 1'b0;
        commit_ev = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = wr_q[AW-1:0];

        unique case (state_q)
            IDLE: begin
                if (acc) begin
                    if (uc_first) begin
                        mem_we = 1'b1;
                        wr_d   = wr_inc;
                        len_d  = LW'(1);
                        if (uc_last) begin
                            cm_d      = wr_inc;
                            commit_ev = 1'b1;
                        end else begin
                            state_d = PKT;
                        end
                    end else begin
                        abt_d = 1'b1;
                        if (!uc_last) begin
                            state_d = DROP;
                        end
                    end
                end
            end

            PKT: begin
                if (deadlock) begin
                    // Packet cannot fit even with an empty reader side: give up on it.
                    wr_d    = cm_q;
                    len_d   = '0;
                    abt_d   = 1'b1;
                    state_d = DROP;
                end else if (acc) begin
                    if (uc_first) begin
                        // Restart: drop the open packet, new beat lands at the commit point.
                        abt_d     = 1'b1;
                        mem_we    = 1'b1;
                        mem_waddr = cm_q[AW-1:0];
                        wr_d      = cm_inc;
                        len_d     = LW'(1);
                        if (uc_last) begin
                            cm_d      = cm_inc;
                            commit_ev = 1'b1;
                            state_d   = IDLE;
                        end
                    end else if (len_q == LW'(MAXLEN)) begin
                        abt_d   = 1'b1;
                        wr_d    = cm_q;
                        len_d   = '0;
                        state_d = uc_last ? IDLE : DROP;
                    end else begin
                        mem_we = 1'b1;
                        wr_d   = wr_inc;
                        len_d  = LW'(len_q + LW'(1));
                        if (uc_last) begin
                            cm_d      = wr_inc;
                            commit_ev = 1'b1;
                            state_d   = IDLE;
                        end
                    end
                end
            end

            DROP: begin
                if (acc && uc_last) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wr_q    <= '0;
            cm_q    <= '0;
            rd_q    <= '0;
            len_q   <= '0;
            abt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            cm_q    <= cm_d;
            len_q   <= len_d;
            abt_q   <= abt_d;
            if (pop) begin
                rd_q <= PW'(rd_q + PW'(1));
            end
        end
    end

    sink_mem #(
        .WIDTH (MW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (rd_q[AW-1:0]),
        .rdata (mem_rdata)
    );

    // Head word is only meaningful when committed data exists.
    assign rd_data  = rd_vld ? mem_rdata[W-1:0] : '0;
    assign rd_last  = rd_vld & mem_rdata[W];
    assign rd_first = rd_vld & mem_rdata[W+1];

`ifdef STREAM_SINK_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt <= '0;
            abt_cnt <= '0;
        end else begin
            if (commit_ev) begin
                pkt_cnt <= sat_inc16(pkt_cnt);
            end
            if (abt_q) begin
                abt_cnt <= sat_inc16(abt_cnt);
            end
        end
    end
`else
    logic unused_commit;
    assign unused_commit = commit_ev;
`endif

endmodule

// File: tb/tb_stream_pkt_sink.sv
// Directed scoreboard bench for stream_pkt_sink: two instances (MAXLEN 256 and 4).
module tb_stream_pkt_sink;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic [31:0] uc_d0 = '0;
    logic [3:0]  uc_mflags = '0;
    logic        rd_rdy = 1'b0;

    logic [3:0]  a_mflags, m_mflags;
    logic        a_rdy, m_rdy;
    logic [1:0]  a_sflags, m_sflags;
    logic [31:0] a_data, m_data;
    logic        a_first, a_last, a_vld, m_first, m_last, m_vld;

    logic [1:0]  sflags_o;
    logic [31:0] data_o;
    logic        first_o, last_o, vld_o, bsy_o, abt_o;

    int checks = 0;
    int errors = 0;
    int abt_seen = 0;
    int abt_run = 0;
    int last_run = 0;
    logic [33:0] sb [$];

    always #5 clk = ~clk;

    assign a_mflags = sel ? 4'h0 : uc_mflags;
    assign m_mflags = sel ? uc_mflags : 4'h0;
    assign a_rdy    = sel ? 1'b0 : rd_rdy;
    assign m_rdy    = sel ? rd_rdy : 1'b0;

    assign sflags_o = sel ? m_sflags : a_sflags;
    assign data_o   = sel ? m_data   : a_data;
    assign first_o  = sel ? m_first  : a_first;
    assign last_o   = sel ? m_last   : a_last;
    assign vld_o    = sel ? m_vld    : a_vld;
    assign bsy_o    = sflags_o[0];
    assign abt_o    = sflags_o[1];

    stream_pkt_sink #(.W(32), .DEPTH(16), .MAXLEN(256)) u_a (
        .clk(clk), .rst_n(rst_n), .uc_d0(uc_d0), .uc_mflags(a_mflags),
        .cu_sflags(a_sflags), .rd_data(a_data), .rd_first(a_first),
        .rd_last(a_last), .rd_vld(a_vld), .rd_rdy(a_rdy)
    );

    stream_pkt_sink #(.W(32), .DEPTH(16), .MAXLEN(4)) u_m (
        .clk(clk), .rst_n(rst_n), .uc_d0(uc_d0), .uc_mflags(m_mflags),
        .cu_sflags(m_sflags), .rd_data(m_data), .rd_first(m_first),
        .rd_last(m_last), .rd_vld(m_vld), .rd_rdy(m_rdy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reader side: every pop must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n) begin
            if (abt_o) begin
                abt_seen++;
                abt_run++;
            end else if (abt_run > 0) begin
                last_run = abt_run;
                abt_run  = 0;
            end
            if (vld_o && rd_rdy) begin
                check("pop_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    check("rd_word", 64'({first_o, last_o, data_o}), 64'(sb.pop_front()));
                end
            end
        end
    end

    task automatic send(input logic f, input logic l, input logic [31:0] d);
        int n = 0;
        @(posedge clk);
        #1;
        uc_d0     = d;
        uc_mflags = {1'b0, f, l, 1'b1};
        @(negedge clk);
        while (bsy_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("send_timeout", 64'(n), 64'd0);
        @(posedge clk);
        #1;
        uc_mflags = 4'h0;
    endtask

    task automatic send_again(input logic f, input logic l, input logic [31:0] d);
        @(posedge clk);
        #1;
        uc_d0     = d;
        uc_mflags = {1'b1, f, l, 1'b1};
        @(posedge clk);
        #1;
        uc_mflags = 4'h0;
    endtask

    task automatic push(input logic f, input logic l, input logic [31:0] d);
        sb.push_back({f, l, d});
    endtask

    task automatic drain(input string tag);
        int n = 0;
        rd_rdy = 1'b1;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
        check({tag, "_vld_idle"}, 64'(vld_o), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_sflags", 64'(sflags_o), 64'd0);
        check("rst_vld", 64'(vld_o), 64'd0);
        check("rst_data", 64'(data_o), 64'd0);
        check("rst_first_last", 64'({first_o, last_o}), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single-beat packet
        a0 = abt_seen;
        rd_rdy = 1'b1;
        push(1'b1, 1'b1, 32'hA5);
        send(1'b1, 1'b1, 32'hA5);
        @(negedge clk);
        check("single_vld", 64'(vld_o), 64'd1);
        check("single_data", 64'(data_o), 64'hA5);
        check("single_fl", 64'({first_o, last_o}), 64'd3);
        drain("single");
        check("single_no_abt", 64'(abt_seen - a0), 64'd0);

        // Fill with two 8-beat packets, then hold a third packet's first beat
        rd_rdy = 1'b0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 8; i++) begin
                push(i == 0, i == 7, 32'h100 + 32'(p * 16 + i));
                send(i == 0, i == 7, 32'h100 + 32'(p * 16 + i));
            end
        end
        @(negedge clk);
        check("fill_bsy", 64'(bsy_o), 64'd1);
        check("fill_vld", 64'(vld_o), 64'd1);
        @(posedge clk);
        #1;
        uc_d0     = 32'h300;
        uc_mflags = 4'b0101;
        push(1'b1, 1'b0, 32'h300);
        repeat (3) @(negedge clk);
        check("held_bsy", 64'(bsy_o), 64'd1);
        @(posedge clk);
        #1;
        rd_rdy = 1'b1;
        @(posedge clk);
        #1;
        rd_rdy = 1'b0;
        @(negedge clk);
        check("bsy_after_pop", 64'(bsy_o), 64'd0);
        @(posedge clk);
        #1;
        uc_mflags = 4'h0;
        @(negedge clk);
        check("refull_bsy", 64'(bsy_o), 64'd1);
        rd_rdy = 1'b1;
        push(1'b0, 1'b1, 32'h301);
        send(1'b0, 1'b1, 32'h301);
        drain("fill");

        // Mid-packet restart
        a0 = abt_seen;
        send(1'b1, 1'b0, 32'h1);
        send(1'b0, 1'b0, 32'h2);
        send(1'b0, 1'b0, 32'h3);
        push(1'b1, 1'b0, 32'h10);
        send(1'b1, 1'b0, 32'h10);
        @(negedge clk);
        check("midpkt_abt", 64'(abt_o), 64'd1);
        push(1'b0, 1'b1, 32'h11);
        send(1'b0, 1'b1, 32'h11);
        drain("midpkt");
        check("midpkt_abt_cnt", 64'(abt_seen - a0), 64'd1);

        // Packet larger than the FIFO: deadlock abort
        a0 = abt_seen;
        for (int i = 1; i <= 20; i++) begin
            send(i == 1, i == 20, 32'h400 + 32'(i));
        end
        repeat (3) @(negedge clk);
        check("dl_abt_cnt", 64'(abt_seen - a0), 64'd1);
        check("dl_abt_width", 64'(last_run), 64'd1);
        check("dl_vld", 64'(vld_o), 64'd0);
        for (int i = 0; i < 3; i++) begin
            push(i == 0, i == 2, 32'h500 + 32'(i));
            send(i == 0, i == 2, 32'h500 + 32'(i));
        end
        drain("dl_next");
        check("dl_next_no_abt", 64'(abt_seen - a0), 64'd1);

        // again beats are ignored
        a0 = abt_seen;
        send_again(1'b0, 1'b0, 32'hBAD0);
        push(1'b1, 1'b0, 32'h21);
        send(1'b1, 1'b0, 32'h21);
        send_again(1'b1, 1'b0, 32'hBAD1);
        push(1'b0, 1'b0, 32'h22);
        send(1'b0, 1'b0, 32'h22);
        send_again(1'b0, 1'b1, 32'hBAD2);
        push(1'b0, 1'b1, 32'h23);
        send(1'b0, 1'b1, 32'h23);
        drain("again");
        check("again_no_abt", 64'(abt_seen - a0), 64'd0);

        // Asynchronous reset mid-packet drops committed and open data
        rd_rdy = 1'b0;
        send(1'b1, 1'b1, 32'h31);
        send(1'b1, 1'b0, 32'h41);
        send(1'b0, 1'b0, 32'h42);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_sflags", 64'(sflags_o), 64'd0);
        check("arst_vld", 64'(vld_o), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_vld", 64'(vld_o), 64'd0);
        check("post_rst_sflags", 64'(sflags_o), 64'd0);
        a0 = abt_seen;
        rd_rdy = 1'b1;
        push(1'b1, 1'b1, 32'h55);
        send(1'b1, 1'b1, 32'h55);
        drain("post_rst");
        check("post_rst_idle", 64'(abt_seen - a0), 64'd0);

        // MAXLEN=4 instance: 6-beat packet aborted at beat 5
        rd_rdy = 1'b0;
        @(posedge clk);
        #1;
        sel = 1'b1;
        rd_rdy = 1'b1;
        a0 = abt_seen;
        for (int i = 1; i <= 6; i++) begin
            send(i == 1, i == 6, 32'h60 + 32'(i));
            if (i == 4) begin
                @(negedge clk);
                check("maxlen_no_abt_b4", 64'(abt_o), 64'd0);
            end
            if (i == 5) begin
                @(negedge clk);
                check("maxlen_abt_b5", 64'(abt_o), 64'd1);
            end
        end
        push(1'b1, 1'b0, 32'h71);
        send(1'b1, 1'b0, 32'h71);
        push(1'b0, 1'b1, 32'h72);
        send(1'b0, 1'b1, 32'h72);
        drain("maxlen");
        check("maxlen_abt_cnt", 64'(abt_seen - a0), 64'd1);
        check("maxlen_abt_width", 64'(last_run), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
